// File: rtl/div_pkg.sv
// Shared divider definitions: op encoding (funct3[1:0]), FSM state codes and
// the divide-by-zero quotient constant.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        DS_IDLE   = 2'b00,
        DS_DIVIDE = 2'b01,
        DS_FIX    = 2'b10,
        DS_DONE   = 2'b11
    } div_state_t;

    localparam int DIV_MAX_W = 64;
    // Quotient returned for a zero divisor; sliced down to the operand width.
    localparam logic [DIV_MAX_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  kill;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, op, src_a, src_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src_a, src_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up in a final cycle, single-cycle bypass for div-by-zero and overflow.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] ST_IDLE   = DS_IDLE;
    localparam logic [1:0] ST_DIVIDE = DS_DIVIDE;
    localparam logic [1:0] ST_FIX    = DS_FIX;
    localparam logic [1:0] ST_DONE   = DS_DONE;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;   // dividend shifts out the top, quotient bits shift in
    logic [DATA_WIDTH-1:0] dvs;
    logic                  neg_q;
    logic                  neg_r;
    logic                  sel_rem;
    logic [DATA_WIDTH-1:0] result_q;

    div_op_t               op_e;
    logic                  is_signed;
    logic                  accept;
    logic                  div_zero;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] fix_q;
    logic [DATA_WIDTH-1:0] fix_r;

    always_comb begin
        op_e      = div_op_t'(bus.op);
        is_signed = (op_e == DIV) || (op_e == REM);
        accept    = bus.start && !bus.kill && (state == ST_IDLE || state == ST_DONE);
        div_zero  = (bus.src_b == '0);
        ovf       = is_signed && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
        a_mag     = (is_signed && bus.src_a[DATA_WIDTH-1]) ? -bus.src_a : bus.src_a;
        b_mag     = (is_signed && bus.src_b[DATA_WIDTH-1]) ? -bus.src_b : bus.src_b;
        // Partial remainder is always below the divisor, so W+1 bits never overflow.
        trial     = {rem, quo[DATA_WIDTH-1]} - {1'b0, dvs};
        fix_q     = neg_q ? -quo : quo;
        fix_r     = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_rem  <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        sel_rem <= bus.op[1];
                        if (div_zero) begin
                            result_q <= bus.op[1] ? bus.src_a : DIV_ZERO_QUOT[DATA_WIDTH-1:0];
                            state    <= ST_DONE;
                        end else if (ovf) begin
                            result_q <= bus.op[1] ? '0 : MIN_NEG;
                            state    <= ST_DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            neg_q <= is_signed && (bus.src_a[DATA_WIDTH-1] ^ bus.src_b[DATA_WIDTH-1]);
                            neg_r <= is_signed && bus.src_a[DATA_WIDTH-1];
                            count <= '0;
                            state <= ST_DIVIDE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DIVIDE: begin
                    if (!trial[DATA_WIDTH])
                        rem <= trial[DATA_WIDTH-1:0];
                    else
                        rem <= {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
                    quo   <= {quo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_WIDTH - 1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result_q <= sel_rem ? fix_r : fix_q;
                    state    <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == ST_DIVIDE) || (state == ST_FIX);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;

endmodule
